// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: writes one streamed image into a flat frame buffer
// and holds it stable for the classifier until frame_ack.
module pixel_frame_loader #(
  parameter  int NUM_PIXELS = 784,
  parameter  int DATA_WIDTH = 32,
  localparam int CW = $clog2(NUM_PIXELS + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_last,
  output logic [NUM_PIXELS*DATA_WIDTH-1:0] photo,
  output logic                           frame_valid,
  input  logic                           frame_ack,
  output logic [CW-1:0]                  pixel_count,
  output logic                           frame_error
);

  typedef enum logic [1:0] {
    LOAD,
    DROP,
    HOLD
  } state_t;

  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] FULL      = CW'(NUM_PIXELS);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          fv_nxt;
  logic          err_nxt;
  logic          wr_en;
  logic          accept;

  assign s_ready = (state != HOLD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = pixel_count;
    fv_nxt    = frame_valid;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pixel_count == LAST_SLOT) begin
            if (s_last) begin
              state_nxt = HOLD;
              cnt_nxt   = FULL;
              fv_nxt    = 1'b1;
            end else begin
              // long frame: discard the tail until its s_last
              state_nxt = DROP;
              cnt_nxt   = '0;
              err_nxt   = 1'b1;
            end
          end else if (s_last) begin
            cnt_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            cnt_nxt = pixel_count + 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          fv_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
        fv_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      pixel_count <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      pixel_count <= cnt_nxt;
      frame_valid <= fv_nxt;
      frame_error <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      photo <= '0;
    end else if (wr_en) begin
      photo[DATA_WIDTH*int'(pixel_count) +: DATA_WIDTH] <= s_data;
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// tb_pixel_frame_loader: directed frames with a scoreboard that checks
// each completed frame and each error pulse as the loader presents it.
module tb_pixel_frame_loader;

  localparam int NP = 784;
  localparam int DW = 32;
  localparam int CW = $clog2(NP + 1);

  typedef logic [NP*DW-1:0] frame_t;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  frame_t        photo;
  logic          frame_valid;
  logic          frame_ack;
  logic [CW-1:0] pixel_count;
  logic          frame_error;

  int     checks = 0;
  int     errors = 0;
  frame_t exp_frames[$];
  int     exp_errs[$];
  frame_t cur;
  logic   prev_fv = 1'b0;

  pixel_frame_loader #(.NUM_PIXELS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .photo(photo),
    .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .pixel_count(pixel_count),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t mk_frame(input int base);
    frame_t f;
    f = '0;
    for (int p = 0; p < NP; p++) f[DW*p +: DW] = DW'(base + p);
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_frame(input string name, input frame_t act,
                             input frame_t req);
    checks++;
    if (act !== req) begin
      errors++;
      for (int p = 0; p < NP; p++) begin
        if (act[DW*p +: DW] !== req[DW*p +: DW]) begin
          $display("FAIL %s pixel %0d actual=%0h required=%0h", name, p,
                   act[DW*p +: DW], req[DW*p +: DW]);
          break;
        end
      end
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int   n;
    logic rdy;
    logic done;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n       = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout actual=stalled required=accept");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input int base, input int n, input int last_idx,
                            input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(1) == 1)) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(32'(base + i), (i == last_idx));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && !prev_fv) begin
        if (exp_frames.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=frame_valid required=none");
        end else begin
          check_frame("frame_data", photo, exp_frames.pop_front());
          check("frame_count", 32'(pixel_count), NP);
        end
      end
      if (frame_error) begin
        checks++;
        if (exp_errs.size() == 0) begin
          errors++;
          $display("FAIL error_unexpected actual=1 required=0");
        end else begin
          void'(exp_errs.pop_front());
        end
      end
    end
    prev_fv = frame_valid;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_fv", 32'(frame_valid), 0);
    check("rst_count", 32'(pixel_count), 0);
    check("rst_err", 32'(frame_error), 0);
    check_frame("rst_photo", photo, '0);
    @(posedge clk);
    #1;

    // Full frame, then hold behaviour
    cur = mk_frame(0);
    exp_frames.push_back(cur);
    send_frame(0, NP, NP - 1, 1'b0);
    @(negedge clk);
    check("t1_fv_latency", 32'(frame_valid), 1);
    check("t1_count", 32'(pixel_count), NP);
    s_valid = 1'b1;
    s_data  = 32'hdeadbeef;
    s_last  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("hold_ready", 32'(s_ready), 0);
    end
    check_frame("hold_photo", photo, cur);
    check("hold_count", 32'(pixel_count), NP);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    do_ack();
    @(negedge clk);
    check("ack_fv", 32'(frame_valid), 0);
    check("ack_ready", 32'(s_ready), 1);
    check("ack_count", 32'(pixel_count), 0);
    @(posedge clk);
    #1;

    // Short frame then a clean frame
    exp_errs.push_back(1);
    send_frame(100, 100, 99, 1'b0);
    @(negedge clk);
    check("short_count", 32'(pixel_count), 0);
    check("short_fv", 32'(frame_valid), 0);
    @(posedge clk);
    #1;
    exp_frames.push_back(mk_frame(2000));
    send_frame(2000, NP, NP - 1, 1'b0);
    @(negedge clk);
    check("t3_fv", 32'(frame_valid), 1);
    @(posedge clk);
    #1;
    do_ack();

    // Long frame then a clean frame
    exp_errs.push_back(1);
    send_frame(3000, 790, 789, 1'b0);
    @(negedge clk);
    check("long_count", 32'(pixel_count), 0);
    check("long_fv", 32'(frame_valid), 0);
    @(posedge clk);
    #1;
    exp_frames.push_back(mk_frame(4000));
    send_frame(4000, NP, NP - 1, 1'b0);
    @(negedge clk);
    check("t4_fv", 32'(frame_valid), 1);
    @(posedge clk);
    #1;
    do_ack();

    // Back-to-back frames with gaps, ack on first hold cycle
    exp_frames.push_back(mk_frame(0));
    send_frame(0, NP, NP - 1, 1'b1);
    frame_ack = 1'b1;
    exp_frames.push_back(mk_frame(1000));
    fork
      begin
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
      end
      send_frame(1000, NP, NP - 1, 1'b1);
    join
    @(negedge clk);
    check("t5_fv", 32'(frame_valid), 1);
    @(posedge clk);
    #1;
    do_ack();

    // Reset mid-frame
    send_frame(5000, 400, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_frame("midrst_photo", photo, '0);
    check("midrst_count", 32'(pixel_count), 0);
    check("midrst_fv", 32'(frame_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_frames.push_back(mk_frame(6000));
    send_frame(6000, NP, NP - 1, 1'b0);
    @(negedge clk);
    check("t6_fv_latency", 32'(frame_valid), 1);

    repeat (3) @(negedge clk);
    check("frames_left", 32'(exp_frames.size()), 0);
    check("errs_left", 32'(exp_errs.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
